// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with per-entry valid bits, write-conflict
// detection, optional write-to-read bypass and optional registered read ports.
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_WR   = 2,
    parameter int NUM_RD   = 2,
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_WR*ADDR_W-1:0]   WA,
    input  logic [NUM_WR*DATA_W-1:0]   WD,
    input  logic [NUM_WR-1:0]          WE,
    input  logic [NUM_RD*ADDR_W-1:0]   RA,
    input  logic [NUM_RD-1:0]          RE,
    output logic [NUM_RD*DATA_W-1:0]   RD,
    output logic [NUM_RD-1:0]          RV,
    output logic                       CONFLICT
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0]         valid_d;
    logic                     conflict_q;
    logic                     conflict_d;
    logic [NUM_WR-1:0]        wr_eff;
    logic [NUM_RD*DATA_W-1:0] rd_d;
    logic [NUM_RD-1:0]        rv_d;

    always_comb begin
        wr_eff = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            wr_eff[i] = WE[i] && !RST &&
                        !(ZERO_R0 != 0 && WA[i*ADDR_W +: ADDR_W] == '0);
        end
    end

    // Ports are applied in ascending order, so the highest-index port wins a clash.
    always_comb begin
        mem_d      = mem_q;
        valid_d    = valid_q;
        conflict_d = 1'b0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (wr_eff[i]) begin
                mem_d[WA[i*ADDR_W +: ADDR_W]]   = WD[i*DATA_W +: DATA_W];
                valid_d[WA[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
            for (int unsigned k = i + 1; k < NUM_WR; k++) begin
                if (wr_eff[i] && wr_eff[k] &&
                    WA[i*ADDR_W +: ADDR_W] == WA[k*ADDR_W +: ADDR_W]) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Bypass reads the post-write image; it serves both the combinational and registered forms.
    always_comb begin
        rd_d = '0;
        rv_d = '0;
        for (int unsigned j = 0; j < NUM_RD; j++) begin
            if (RE[j] && !RST) begin
                if (ZERO_R0 != 0 && RA[j*ADDR_W +: ADDR_W] == '0) begin
                    rv_d[j] = 1'b1;
                end else if (BYPASS != 0) begin
                    rd_d[j*DATA_W +: DATA_W] = mem_d[RA[j*ADDR_W +: ADDR_W]];
                    rv_d[j]                  = valid_d[RA[j*ADDR_W +: ADDR_W]];
                end else begin
                    rd_d[j*DATA_W +: DATA_W] = mem_q[RA[j*ADDR_W +: ADDR_W]];
                    rv_d[j]                  = valid_q[RA[j*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
            valid_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
        end
    end

    assign CONFLICT = conflict_q;

    generate
        if (READ_LAT != 0) begin : g_rd_reg
            logic [NUM_RD*DATA_W-1:0] rd_q;
            logic [NUM_RD-1:0]        rv_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    rd_q <= '0;
                    rv_q <= '0;
                end else begin
                    rd_q <= rd_d;
                    rv_q <= rv_d;
                end
            end

            assign RD = rd_q;
            assign RV = rv_q;
        end else begin : g_rd_comb
            assign RD = rd_d;
            assign RV = rv_d;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: five parameter variants share one stimulus stream and are
// compared against an array-based model of the register file contents.
module tb_regfile_mp;

    localparam int NC = 5;
    // variant c: bit c of each mask selects ZERO_R0 / BYPASS / READ_LAT
    localparam logic [NC-1:0] ZR  = 5'b01000;
    localparam logic [NC-1:0] BYP = 5'b01101;
    localparam logic [NC-1:0] LAT = 5'b10100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [1:0]  we;
    logic [7:0]  ra;
    logic [1:0]  re;

    logic [31:0] rd_o [NC];
    logic [1:0]  rv_o [NC];
    logic        cf_o [NC];

    logic [15:0] mm  [NC][16];
    logic        mv  [NC][16];
    logic [15:0] erd [NC][2];
    logic        erv [NC][2];
    logic        ecf [NC];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(.ZERO_R0(0), .BYPASS(1), .READ_LAT(0)) u_c0 (
        .CLK(clk), .RST(rst), .WA(wa), .WD(wd), .WE(we), .RA(ra), .RE(re),
        .RD(rd_o[0]), .RV(rv_o[0]), .CONFLICT(cf_o[0]));
    regfile_mp #(.ZERO_R0(0), .BYPASS(0), .READ_LAT(0)) u_c1 (
        .CLK(clk), .RST(rst), .WA(wa), .WD(wd), .WE(we), .RA(ra), .RE(re),
        .RD(rd_o[1]), .RV(rv_o[1]), .CONFLICT(cf_o[1]));
    regfile_mp #(.ZERO_R0(0), .BYPASS(1), .READ_LAT(1)) u_c2 (
        .CLK(clk), .RST(rst), .WA(wa), .WD(wd), .WE(we), .RA(ra), .RE(re),
        .RD(rd_o[2]), .RV(rv_o[2]), .CONFLICT(cf_o[2]));
    regfile_mp #(.ZERO_R0(1), .BYPASS(1), .READ_LAT(0)) u_c3 (
        .CLK(clk), .RST(rst), .WA(wa), .WD(wd), .WE(we), .RA(ra), .RE(re),
        .RD(rd_o[3]), .RV(rv_o[3]), .CONFLICT(cf_o[3]));
    regfile_mp #(.ZERO_R0(0), .BYPASS(0), .READ_LAT(1)) u_c4 (
        .CLK(clk), .RST(rst), .WA(wa), .WD(wd), .WE(we), .RA(ra), .RE(re),
        .RD(rd_o[4]), .RV(rv_o[4]), .CONFLICT(cf_o[4]));

    function automatic logic eff(int c, int i);
        logic [3:0] a;
        a = wa[i*4 +: 4];
        return we[i] && !rst && !(ZR[c] && a == 4'd0);
    endfunction

    // Expected combinational read for a READ_LAT=0 variant with the current inputs.
    function automatic void comb_read(int c, int j, output logic [15:0] d, output logic v);
        logic [3:0] a;
        a = ra[j*4 +: 4];
        d = '0;
        v = 1'b0;
        if (re[j] && !rst) begin
            if (ZR[c] && a == 4'd0) begin
                v = 1'b1;
            end else begin
                d = mm[c][a];
                v = mv[c][a];
                if (BYP[c]) begin
                    for (int i = 1; i >= 0; i--) begin
                        if (eff(c, i) && wa[i*4 +: 4] == a) begin
                            d = wd[i*16 +: 16];
                            v = 1'b1;
                            break;
                        end
                    end
                end
            end
        end
    endfunction

    // One clock edge: advance the model and the expected registered outputs.
    task automatic tick();
        logic [15:0] nm [NC][16];
        logic        nv [NC][16];
        logic [15:0] nrd [NC][2];
        logic        nrv [NC][2];
        logic        ncf [NC];
        int          cnt;
        logic [3:0]  a;
        nm = mm;
        nv = mv;
        for (int c = 0; c < NC; c++) begin
            ncf[c] = 1'b0;
            for (int ad = 0; ad < 16; ad++) begin
                cnt = 0;
                for (int i = 1; i >= 0; i--) begin
                    if (eff(c, i) && wa[i*4 +: 4] == 4'(ad)) begin
                        if (cnt == 0) begin
                            nm[c][ad] = wd[i*16 +: 16];
                            nv[c][ad] = 1'b1;
                        end
                        cnt++;
                    end
                end
                if (cnt > 1) ncf[c] = 1'b1;
                if (rst) begin
                    nm[c][ad] = '0;
                    nv[c][ad] = 1'b0;
                end
            end
            for (int j = 0; j < 2; j++) begin
                a = ra[j*4 +: 4];
                nrd[c][j] = '0;
                nrv[c][j] = 1'b0;
                if (re[j] && !rst) begin
                    if (ZR[c] && a == 4'd0) begin
                        nrv[c][j] = 1'b1;
                    end else if (BYP[c]) begin
                        nrd[c][j] = nm[c][a];
                        nrv[c][j] = nv[c][a];
                    end else begin
                        nrd[c][j] = mm[c][a];
                        nrv[c][j] = mv[c][a];
                    end
                end
            end
        end
        @(posedge clk);
        mm  = nm;
        mv  = nv;
        erd = nrd;
        erv = nrv;
        ecf = ncf;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = '0; re = 2'b11; ra = {4'd3, 4'd3};
        #1;
        checks++;
        if (rd_o[0] !== 32'h0 || rv_o[0] !== 2'b00) begin
            errors++; $display("FAIL reset_comb got rd=%h rv=%b exp rd=0 rv=00", rd_o[0], rv_o[0]);
        end
        tick();
        checks++;
        if (cf_o[0] !== 1'b0 || rd_o[2] !== 32'h0 || rv_o[2] !== 2'b00) begin
            errors++; $display("FAIL reset_regs got cf=%b rd=%h rv=%b exp 0/0/00", cf_o[0], rd_o[2], rv_o[2]);
        end
        rst = 1'b0; re = '0; we = 2'b01; wa = {4'd0, 4'd3}; wd = {16'h0, 16'hBEEF};
        tick();
        we = '0; re = 2'b01; ra = {4'd0, 4'd3};
        #1;
        checks++;
        if (rd_o[0][15:0] !== 16'hBEEF || rv_o[0][0] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_write got rd=%h rv=%b exp BEEF/1", rd_o[0][15:0], rv_o[0][0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rd_o[0][15:0] !== 16'h0 || rv_o[0][0] !== 1'b0) begin
            errors++; $display("FAIL reset_clear got rd=%h rv=%b exp 0000/0", rd_o[0][15:0], rv_o[0][0]);
        end
        re = '0;
        tick();
    endtask

    task automatic test_dual_write();
        we = 2'b11; wa = {4'd5, 4'd2}; wd = {16'h2222, 16'h1111};
        tick();
        we = '0; re = 2'b11; ra = {4'd5, 4'd2};
        #1;
        checks++;
        if (rd_o[0] !== 32'h2222_1111 || rv_o[0] !== 2'b11 || cf_o[0] !== 1'b0) begin
            errors++; $display("FAIL dual_write got rd=%h rv=%b cf=%b exp 22221111/11/0", rd_o[0], rv_o[0], cf_o[0]);
        end
        re = '0;
        tick();
    endtask

    task automatic test_conflict();
        we = 2'b11; wa = {4'd7, 4'd7}; wd = {16'h5555, 16'hAAAA};
        tick();
        we = '0; re = 2'b01; ra = {4'd0, 4'd7};
        #1;
        checks++;
        if (cf_o[0] !== 1'b1 || rd_o[0][15:0] !== 16'h5555) begin
            errors++; $display("FAIL conflict_hit got cf=%b rd=%h exp 1/5555", cf_o[0], rd_o[0][15:0]);
        end
        tick();
        checks++;
        if (cf_o[0] !== 1'b0) begin
            errors++; $display("FAIL conflict_clear got cf=%b exp 0", cf_o[0]);
        end
        re = '0;
    endtask

    task automatic test_bypass();
        we = 2'b01; wa = {4'd0, 4'd4}; wd = {16'h0, 16'h1234}; re = 2'b01; ra = {4'd0, 4'd4};
        #1;
        checks++;
        if (rd_o[0][15:0] !== 16'h1234 || rv_o[0][0] !== 1'b1) begin
            errors++; $display("FAIL bypass_on got rd=%h rv=%b exp 1234/1", rd_o[0][15:0], rv_o[0][0]);
        end
        checks++;
        if (rd_o[1][15:0] !== 16'h0 || rv_o[1][0] !== 1'b0) begin
            errors++; $display("FAIL bypass_off got rd=%h rv=%b exp 0000/0", rd_o[1][15:0], rv_o[1][0]);
        end
        tick();
        we = '0; re = '0;
    endtask

    task automatic test_registered_read();
        we = 2'b01; wa = {4'd0, 4'd9}; wd = {16'h0, 16'h00FF};
        tick();
        we = 2'b10; wa = {4'd9, 4'd0}; wd = {16'hF00F, 16'h0}; re = 2'b01; ra = {4'd0, 4'd9};
        tick();
        checks++;
        if (rd_o[2][15:0] !== 16'hF00F || rv_o[2][0] !== 1'b1) begin
            errors++; $display("FAIL regread_bypass got rd=%h rv=%b exp F00F/1", rd_o[2][15:0], rv_o[2][0]);
        end
        checks++;
        if (rd_o[4][15:0] !== 16'h00FF || rv_o[4][0] !== 1'b1) begin
            errors++; $display("FAIL regread_nobypass got rd=%h rv=%b exp 00FF/1", rd_o[4][15:0], rv_o[4][0]);
        end
        we = '0; re = '0;
        tick();
        checks++;
        if (rd_o[2][15:0] !== 16'h0 || rv_o[2][0] !== 1'b0) begin
            errors++; $display("FAIL regread_disable got rd=%h rv=%b exp 0000/0", rd_o[2][15:0], rv_o[2][0]);
        end
    endtask

    task automatic test_zero_r0();
        we = 2'b11; wa = {4'd0, 4'd0}; wd = {16'h7777, 16'h7777}; re = 2'b01; ra = {4'd0, 4'd0};
        #1;
        checks++;
        if (rd_o[3] !== 32'h0 || rv_o[3] !== 2'b01) begin
            errors++; $display("FAIL zero_r0_read got rd=%h rv=%b exp 00000000/01", rd_o[3], rv_o[3]);
        end
        tick();
        checks++;
        if (cf_o[3] !== 1'b0 || cf_o[0] !== 1'b1) begin
            errors++; $display("FAIL zero_r0_conflict got cf3=%b cf0=%b exp 0/1", cf_o[3], cf_o[0]);
        end
        we = '0;
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic        v;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            we  = 2'($urandom);
            wa  = ($urandom_range(0, 1) != 0) ? 8'($urandom) : {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
            wd  = $urandom;
            re  = 2'($urandom);
            ra  = ($urandom_range(0, 1) != 0) ? 8'($urandom) : {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
            #1;
            for (int c = 0; c < NC; c++) begin
                if (!LAT[c]) begin
                    for (int j = 0; j < 2; j++) begin
                        comb_read(c, j, d, v);
                        checks++;
                        if (rd_o[c][j*16 +: 16] !== d || rv_o[c][j] !== v) begin
                            errors++;
                            $display("FAIL rand_comb c%0d p%0d got rd=%h rv=%b exp %h/%b",
                                     c, j, rd_o[c][j*16 +: 16], rv_o[c][j], d, v);
                        end
                    end
                end
            end
            tick();
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (cf_o[c] !== ecf[c]) begin
                    errors++; $display("FAIL rand_conflict c%0d got %b exp %b", c, cf_o[c], ecf[c]);
                end
                if (LAT[c]) begin
                    for (int j = 0; j < 2; j++) begin
                        checks++;
                        if (rd_o[c][j*16 +: 16] !== erd[c][j] || rv_o[c][j] !== erv[c][j]) begin
                            errors++;
                            $display("FAIL rand_reg c%0d p%0d got rd=%h rv=%b exp %h/%b",
                                     c, j, rd_o[c][j*16 +: 16], rv_o[c][j], erd[c][j], erv[c][j]);
                        end
                    end
                end
            end
        end
        rst = 1'b0; we = '0; re = '0;
    endtask

    initial begin
        rst = 1'b1; we = '0; wa = '0; wd = '0; re = '0; ra = '0;
        tick();
        test_reset();
        test_dual_write();
        test_conflict();
        test_bypass();
        test_registered_read();
        test_zero_r0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the 16x16 dual-write/dual-read file. Configurable data width, depth, write-port count and read-port count. Adds synchronous clear, per-entry valid tracking, deterministic write-conflict priority with a conflict flag, optional write-to-read bypass and optional registered reads. Sits between the datapath control and the ALU operand buses.

Parameters:
DATA_W, 16, data width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
NUM_WR, 2, number of write ports (1..4)
NUM_RD, 2, number of read ports (1..4)
ZERO_R0, 0, 1 = entry 0 is hard-wired: reads 0 with valid 1, and writes to it are dropped
BYPASS, 1, 1 = a read returns data written at the same clock edge; 0 = a read returns pre-write contents
READ_LAT, 0, 0 = combinational read; 1 = read data registered, one-cycle latency

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  reset, synchronous, active-high
WA   in  NUM_WR*ADDR_W  write addresses; port i uses [i*ADDR_W +: ADDR_W]
WD   in  NUM_WR*DATA_W  write data; port i uses [i*DATA_W +: DATA_W]
WE   in  NUM_WR  write enables, one per port
RA   in  NUM_RD*ADDR_W  read addresses, packed as WA
RE   in  NUM_RD  read enables
RD   out NUM_RD*DATA_W  read data, packed as WD
RV   out NUM_RD  read valid: addressed entry has been written since reset
CONFLICT out 1  registered; 1 for one cycle after an edge where two or more effective writes hit the same address

Behaviour:
- Reset: on a rising edge with RST=1, all entries are cleared to 0 and all valid bits to 0. Registered RD, RV and CONFLICT are cleared to 0. Writes in that cycle are ignored.
- While RST=1 with READ_LAT=0, RD and RV are forced to 0.
- Effective write: WE[i]=1, RST=0, and not (ZERO_R0=1 and WA[i]=0). On the edge, the entry is written with WD[i] and its valid bit is set.
- Write conflict: when several effective writes target one address, the highest-index port wins. No partial or merged data. CONFLICT=1 on the following cycle only and is not sticky. Distinct addresses always write in parallel.
- Read disabled (RE[j]=0): RD slice = 0 and RV[j] = 0. No tri-state anywhere.
- READ_LAT=0, BYPASS=0: RD[j] = entry[RA[j]] and RV[j] = valid[RA[j]], combinationally.
- READ_LAT=0, BYPASS=1: if an effective write targets RA[j] this cycle, RD[j] = winning WD and RV[j] = 1. Otherwise behaves as BYPASS=0. Combinational path from WA/WD/WE to RD is accepted.
- READ_LAT=1: RE/RA are sampled at the edge, and RD/RV update at that edge. With BYPASS=1 they reflect contents after that edge's writes; with BYPASS=0, contents before. RE=0 at the edge gives RD=0 and RV=0 the next cycle.
- ZERO_R0=1: a read of address 0 returns 0 with RV=1 (when RE=1, RST=0). Writes to 0 never count toward CONFLICT.
- Address range is always full (DEPTH = 2**ADDR_W), so there is no out-of-range case.
- Any number of read ports may read the same address concurrently.
- Reset mid-stream: with READ_LAT=1, a read issued in the RST cycle returns 0/0.

Test Plan:
- Reset clear (defaults): write 0xBEEF to addr 3, assert RST one cycle, read addr 3 -> RD=0x0000, RV=0.
- Dual write, distinct addresses: WA0=2/WD0=0x1111 and WA1=5/WD1=0x2222, both WE=1; next cycle read ports 0/1 at 2/5 -> 0x1111/0x2222, RV=11, CONFLICT=0.
- Write conflict: WA0=WA1=7, WD0=0xAAAA, WD1=0x5555, both WE -> entry 7 = 0x5555, CONFLICT=1 for exactly one cycle, then 0.
- Bypass (READ_LAT=0): RA0=4 with WE0=1, WA0=4, WD0=0x1234 in the same cycle. BYPASS=1 -> RD0=0x1234, RV0=1 before the edge. BYPASS=0 -> old value (0, RV0=0).
- Registered read (READ_LAT=1, BYPASS=1): entry 9 = 0x00FF; set RA0=9, RE0=1 and WA1=9, WD1=0xF00F at edge N -> RD0=0xF00F after edge N. RE0=0 at edge N+1 -> RD0=0 after edge N+1.
- ZERO_R0=1: write 0x7777 to addr 0 on both ports -> read addr 0 gives RD=0, RV=1, CONFLICT=0. Read disabled on port 1 -> RD1=0, RV1=0.
